// File: rtl/adder_pkg.sv
// Shared constants and parameter checks for the pipelined adder family.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // True when WIDTH can be split into STAGES equal chunks.
  function automatic bit legal_split(input int width, input int stages);
    if (width < 1 || stages < 1) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational N-bit adder slice with carry in/out; one per pipeline stage.
module chunk_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES register stages, each resolving WIDTH/STAGES
// bits, with a valid/ready handshake and a global stall driven by the output side.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CHUNK = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;

  if (!legal_split(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH=%0d must be >= 1 and divisible by STAGES=%0d (>= 1)",
           WIDTH, STAGES);
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !reset;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operands still to be added, realigned so this stage's chunk sits at bit 0.
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]         a_src;
    logic [REM-1:0]         b_src;
    logic                   c_src;
    logic                   v_src;
    logic [CHUNK-1:0]       s;
    logic                   co;
    logic [(k+1)*CHUNK-1:0] res_nxt;
    logic [(k+1)*CHUNK-1:0] res_q;
    logic                   v_q;
    logic                   c_q;

    chunk_adder #(.N(CHUNK)) u_chunk (
      .a    (a_src[CHUNK-1:0]),
      .b    (b_src[CHUNK-1:0]),
      .cin  (c_src),
      .s    (s),
      .cout (co)
    );

    if (k == 0) begin : g_head
      assign a_src   = a;
      assign b_src   = b;
      assign c_src   = cin;
      assign v_src   = in_valid && in_ready;
      assign res_nxt = s;
    end else begin : g_body
      assign a_src   = g_stage[k-1].g_fwd.a_rem;
      assign b_src   = g_stage[k-1].g_fwd.b_rem;
      assign c_src   = g_stage[k-1].c_q;
      assign v_src   = g_stage[k-1].v_q;
      assign res_nxt = {s, g_stage[k-1].res_q};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        v_q   <= v_src;
        c_q   <= co;
        res_q <= res_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_rem;
      logic [REM-CHUNK-1:0] b_rem;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (advance) begin
          a_rem <= a_src[REM-1:CHUNK];
          b_rem <= b_src[REM-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].res_q;
  assign cout      = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 16-bit/4-stage instance with directed and
// random traffic, plus a 2-bit/2-stage instance swept over every operand combination.
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int W2 = 2;
  localparam int S2 = 2;

  typedef struct {
    logic [W:0] exp;
    int         acc;
    bit         lat;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [W-1:0]  a, b, sum;
  logic          in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2;
  logic [W2-1:0] a2, b2, sum2;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit lat_mode   = 1'b0;

  item_t         q[$];
  logic [W2:0]   q2[$];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  pipelined_adder #(.WIDTH(W2), .STAGES(S2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard producers: the reference result is plain integer addition.
  always @(negedge clk) begin
    if (reset) q.delete();
    else if (in_valid && in_ready)
      q.push_back('{exp: (W+1)'(a) + (W+1)'(b) + (W+1)'(cin), acc: cyc + 1, lat: lat_mode});
  end

  always @(negedge clk) begin
    if (reset) q2.delete();
    else if (in_valid2 && in_ready2)
      q2.push_back((W2+1)'(a2) + (W2+1)'(b2) + (W2+1)'(cin2));
  end

  // Monitors.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_out: got sum=0x%0h cout=%0d, required no result", sum, cout);
      end else begin
        check("sum", 32'(sum), 32'(q[0].exp[W-1:0]));
        check("cout", 32'(cout), 32'(q[0].exp[W]));
        if (!out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end else begin
          if (q[0].lat) check("latency", 32'(cyc), 32'(q[0].acc + S - 1));
          void'(q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid2) begin
      if (q2.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_out_w2: got sum=0x%0h cout=%0d, required no result", sum2, cout2);
      end else begin
        check("sum_w2", 32'(sum2), 32'(q2[0][W2-1:0]));
        check("cout_w2", 32'(cout2), 32'(q2[0][W2]));
        if (out_ready2) void'(q2.pop_front());
      end
    end
  end

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    a        = xa;
    b        = xb;
    cin      = xc;
    in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: got in_ready=0, required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    out_ready  = 1'b1;
    out_ready2 = 1'b1;
    for (int i = 0; i < 200 && (q.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check("drain_main", 32'(q.size()), 32'd0);
    check("drain_w2", 32'(q2.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;  in_valid = 1'b0;  out_ready = 1'b1;  a = '0;  b = '0;  cin = 1'b0;
    in_valid2 = 1'b0;  out_ready2 = 1'b1;  a2 = '0;  b2 = '0;  cin2 = 1'b0;

    // Two reset edges, then release.
    @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid_w2", 32'(out_valid2), 32'd0);

    // Chunk-boundary carry, full ripple, and 8 back-to-back ops with latency checks.
    @(posedge clk);
    #1;
    lat_mode = 1'b1;
    issue(16'h00FF, 16'h0001, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b1);
    for (int i = 1; i <= 8; i++) issue(W'(i), W'(32'h1000 * i), 1'b0);
    in_valid = 1'b0;
    lat_mode = 1'b0;
    wait_drain();

    // Fill the pipe, stall the output for 3 cycles with a pending input.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    a = W'($urandom);  b = W'($urandom);  cin = 1'b1;  in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check("resume_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // Three operations in flight, then a one-cycle reset discards them.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_out_valid_later", 32'(out_valid), 32'd0);
    end

    // Random traffic with random backpressure.
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    wait_drain();

    // Exhaustive sweep of the 2-bit / 2-stage instance.
    @(posedge clk);
    #1;
    for (int x = 0; x < 32; x++) begin
      logic [4:0] v;
      v          = 5'(x);
      a2         = v[4:3];
      b2         = v[2:1];
      cin2       = v[0];
      in_valid2  = 1'b1;
      out_ready2 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (in_ready2) break;
        out_ready2 = 1'b1;
      end
      if (!in_ready2) begin
        compared++;
        mismatched++;
        $display("FAIL issue_timeout_w2: got in_ready=0, required 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
